// File: rtl/sram_ctrl_defs.sv
// Shared state encodings, default sizes and strobe patterns for the
// SRAM access sequencer and its bench.
package sram_ctrl_defs;

  localparam int DEF_WIDTH         = 16;
  localparam int DEF_ADDR_BITS     = 17;
  localparam int DEF_ACCESS_CYCLES = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACTIVE,
    ST_CAPTURE,
    ST_DONE,
    ST_VSETUP,
    ST_VACTIVE,
    ST_VCAPTURE
  } state_t;

  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
  } strobe_t;

  localparam strobe_t STB_IDLE  = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1};
  localparam strobe_t STB_READ  = '{ce_n: 1'b0, oe_n: 1'b0, we_n: 1'b1};
  localparam strobe_t STB_WRITE = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b0};

endpackage

// File: rtl/sram_access_ctrl_if.sv
// Host-side request/response bundle of the SRAM access sequencer.
// master = host, slave = controller.
interface sram_access_ctrl_if
  import sram_ctrl_defs::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ADDR_BITS = DEF_ADDR_BITS
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [ADDR_BITS-1:0] req_addr;
  logic [WIDTH-1:0]     req_wdata;
  logic                 rsp_valid;
  logic [WIDTH-1:0]     rsp_rdata;
  logic                 rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/sram_cycle_timer.sv
// Loadable down-counter timing one SRAM access window; done marks the
// last enabled cycle.
module sram_cycle_timer #(
  parameter int CYCLES = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic done
);
  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(CYCLES);
    end else if (en && cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign done = en && (cnt == CW'(1));
endmodule

// File: rtl/sram_access_ctrl.sv
// Single-beat request to async-SRAM strobe sequencer.
// Optional write read-back check: SRAM_CTRL_VERIFY_EN.
module sram_access_ctrl
  import sram_ctrl_defs::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int ADDR_BITS     = DEF_ADDR_BITS,
  parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sram_access_ctrl_if.slave    host,
  output logic                 sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n,
  output logic [ADDR_BITS-1:0] sram_addr,
  output logic [WIDTH-1:0]     sram_wdata,
  input  logic [WIDTH-1:0]     sram_rdata
);
  state_t     state_q, state_d;
  strobe_t    stb_q, stb_d;
  logic       wr_q;
  logic       accept;
  logic       tmr_load, tmr_en, tmr_done;
  logic       rsp_valid_q;
  logic [WIDTH-1:0] rdata_q;

  assign accept = host.req_valid && (state_q == ST_IDLE);

`ifdef SRAM_CTRL_VERIFY_EN
  assign tmr_load = (state_q == ST_SETUP) || (state_q == ST_VSETUP);
  assign tmr_en   = (state_q == ST_ACTIVE) || (state_q == ST_VACTIVE);
`else
  assign tmr_load = (state_q == ST_SETUP);
  assign tmr_en   = (state_q == ST_ACTIVE);
`endif

  sram_cycle_timer #(
    .CYCLES (ACCESS_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .en    (tmr_en),
    .done  (tmr_done)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (accept) state_d = ST_SETUP;
      ST_SETUP:   state_d = ST_ACTIVE;
      ST_ACTIVE:  if (tmr_done) state_d = ST_CAPTURE;
`ifdef SRAM_CTRL_VERIFY_EN
      ST_CAPTURE: state_d = wr_q ? ST_VSETUP : ST_DONE;
      ST_VSETUP:  state_d = ST_VACTIVE;
      ST_VACTIVE: if (tmr_done) state_d = ST_VCAPTURE;
      ST_VCAPTURE: state_d = ST_DONE;
`else
      ST_CAPTURE: state_d = ST_DONE;
`endif
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Strobes come from the next state so they change only on edges.
  always_comb begin
    stb_d = STB_IDLE;
    unique case (1'b1)
      (state_d == ST_ACTIVE) &&  wr_q: stb_d = STB_WRITE;
      (state_d == ST_ACTIVE) && !wr_q: stb_d = STB_READ;
`ifdef SRAM_CTRL_VERIFY_EN
      (state_d == ST_VACTIVE):         stb_d = STB_READ;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      stb_q       <= STB_IDLE;
      wr_q        <= 1'b0;
      sram_addr   <= '0;
      sram_wdata  <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stb_q       <= stb_d;
      rsp_valid_q <= (state_d == ST_DONE);
      if (accept) begin
        wr_q       <= host.req_write;
        sram_addr  <= host.req_addr;
        sram_wdata <= host.req_wdata;
      end
      if ((state_q == ST_ACTIVE) && tmr_done && !wr_q) begin
        rdata_q <= sram_rdata;
      end
    end
  end

`ifdef SRAM_CTRL_VERIFY_EN
  logic mis_q;
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (accept) begin
        mis_q <= 1'b0;
      end else if ((state_q == ST_VACTIVE) && tmr_done) begin
        mis_q <= (sram_rdata != sram_wdata);
      end
      err_q <= (state_d == ST_DONE) && mis_q;
    end
  end

  assign host.rsp_err = err_q;
`else
  assign host.rsp_err = 1'b0;
`endif

  assign host.req_ready = (state_q == ST_IDLE);
  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_rdata = rdata_q;
  assign sram_ce_n      = stb_q.ce_n;
  assign sram_oe_n      = stb_q.oe_n;
  assign sram_we_n      = stb_q.we_n;
endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: directed table, streaming and reset
// sequences, then randomized traffic against an array reference model.
`timescale 1ns/1ps
module tb_sram_access_ctrl;
  import sram_ctrl_defs::*;

  parameter int N = DEF_ACCESS_CYCLES;
  localparam int W  = 16;
  localparam int AB = 17;
`ifdef SRAM_CTRL_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce_n, oe_n, we_n;
  logic [AB-1:0] sram_addr;
  logic [W-1:0]  sram_wdata, sram_rdata;
  logic [W-1:0]  mem [0:(1<<AB)-1];
  logic          flip = 1'b0;

  sram_access_ctrl_if #(.WIDTH(W), .ADDR_BITS(AB)) host ();

  sram_access_ctrl #(
    .WIDTH(W), .ADDR_BITS(AB), .ACCESS_CYCLES(N)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .host       (host),
    .sram_ce_n  (ce_n),
    .sram_oe_n  (oe_n),
    .sram_we_n  (we_n),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  always #5 clk = ~clk;

  // Async SRAM stand-in; flip corrupts bit 0 of whatever is read out.
  always_ff @(posedge clk) begin
    if (!ce_n && !we_n) mem[sram_addr] <= sram_wdata;
  end
  assign sram_rdata = (!ce_n && !oe_n) ?
    (mem[sram_addr] ^ {{(W-1){1'b0}}, flip}) : 16'hDEAD;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  int m_lat, m_ce, m_we, m_oe, m_ovl, m_abad;
  logic [W-1:0] m_rd;
  logic m_er, m_tail;

  task automatic do_req(input logic w, input logic [AB-1:0] a,
                        input logic [W-1:0] d);
    int t;
    @(negedge clk);
    host.req_valid = 1'b1;
    host.req_write = w;
    host.req_addr  = a;
    host.req_wdata = d;
    t = 0;
    while (!host.req_ready && t < 64) begin
      @(negedge clk);
      t++;
    end
    chk("req_accept", 32'(t < 64), 32'd1);
    @(posedge clk);
    #1;
    host.req_valid = 1'b0;
    host.req_write = ~w;
    host.req_addr  = a ^ 17'h1_5A5A;
    host.req_wdata = ~d;
    m_lat = 0; m_ce = 0; m_we = 0; m_oe = 0; m_ovl = 0; m_abad = 0;
    do begin
      @(posedge clk);
      #1;
      m_lat++;
      if (!ce_n) m_ce++;
      if (!we_n) m_we++;
      if (!oe_n) m_oe++;
      if (!oe_n && !we_n) m_ovl++;
      if (sram_addr !== a || (w && sram_wdata !== d)) m_abad++;
    end while (!host.rsp_valid && m_lat < 64);
    m_rd = host.rsp_rdata;
    m_er = host.rsp_err;
    @(posedge clk);
    #1;
    m_tail = host.rsp_valid;
  endtask

  function automatic int lat_of(input logic w);
    return (w && VER) ? 2*N + 4 : N + 2;
  endfunction

  task automatic run_vec(input string nm, input logic w,
                         input logic [AB-1:0] a, input logic [W-1:0] d,
                         input logic [W-1:0] erd, input logic eer);
    do_req(w, a, d);
    chk({nm, ".latency"}, m_lat, lat_of(w));
    chk({nm, ".rdata"}, m_rd, erd);
    chk({nm, ".err"}, m_er, eer);
    chk({nm, ".pulse_1cyc"}, m_tail, 0);
    chk({nm, ".ce_low"}, m_ce, (w && VER) ? 2*N : N);
    chk({nm, ".we_low"}, m_we, w ? N : 0);
    chk({nm, ".oe_low"}, m_oe, (!w || VER) ? N : 0);
    chk({nm, ".overlap"}, m_ovl, 0);
    chk({nm, ".addr_data_stable"}, m_abad, 0);
  endtask

  typedef struct {
    logic          w;
    logic [AB-1:0] a;
    logic [W-1:0]  d;
    logic [W-1:0]  rd;
    logic          er;
  } vec_t;

  vec_t tbl [8];
  logic [W-1:0] exp_last;
  logic [W-1:0] ref_mem [logic [AB-1:0]];

  task automatic t3_stream();
    logic          ws [4];
    logic [AB-1:0] as [4];
    logic [W-1:0]  ds [4];
    int acc [4];
    int na, ce_hi, min_gap, ovl, bound;
    bit seen, acc_gap, pend;
    ws = '{1'b1, 1'b0, 1'b1, 1'b0};
    as = '{17'h0_AAAA, 17'h0_AAAA, 17'h1_5555, 17'h1_5555};
    ds = '{16'h5A5A, 16'h0000, 16'hC3C3, 16'h0000};
    acc = '{0, 0, 0, 0};
    na = 0; ce_hi = 0; min_gap = 99; ovl = 0;
    seen = 0; acc_gap = 0;
    bound = 4 * (2*N + 6) + 8;
    @(negedge clk);
    host.req_valid = 1'b1;
    host.req_write = ws[0];
    host.req_addr  = as[0];
    host.req_wdata = ds[0];
    for (int c = 0; c < bound; c++) begin
      pend = host.req_valid && host.req_ready;
      @(posedge clk);
      if (pend) begin
        if (na < 4) acc[na] = c;
        na++;
        acc_gap = 1;
      end
      @(negedge clk);
      if (pend) begin
        if (na < 4) begin
          host.req_write = ws[na];
          host.req_addr  = as[na];
          host.req_wdata = ds[na];
        end else begin
          host.req_valid = 1'b0;
        end
      end
      if (!oe_n && !we_n) ovl++;
      if (!ce_n) begin
        if (seen && acc_gap && ce_hi < min_gap) min_gap = ce_hi;
        seen = 1; acc_gap = 0; ce_hi = 0;
      end else begin
        ce_hi++;
      end
    end
    chk("t3.accepts", na, 4);
    for (int i = 0; i < 3; i++)
      chk($sformatf("t3.spacing%0d", i), acc[i+1] - acc[i],
          lat_of(ws[i]) + 2);
    chk("t3.ce_gap_ge3", 32'(min_gap >= 3), 32'd1);
    chk("t3.overlap", ovl, 0);
    chk("t3.rdata", host.rsp_rdata, 16'hC3C3);
    ref_mem[as[0]] = ds[0];
    ref_mem[as[2]] = ds[2];
    exp_last = 16'hC3C3;
  endtask

  initial begin
    int seen_v;
    host.req_valid = 1'b0;
    host.req_write = 1'b0;
    host.req_addr  = '0;
    host.req_wdata = '0;

    tbl[0] = '{w: 1'b1, a: 17'h1_2345, d: 16'hBEEF, rd: 16'h0000, er: 1'b0};
    tbl[1] = '{w: 1'b0, a: 17'h1_2345, d: 16'h0000, rd: 16'hBEEF, er: 1'b0};
    tbl[2] = '{w: 1'b1, a: 17'h0_0000, d: 16'h0000, rd: 16'hBEEF, er: 1'b0};
    tbl[3] = '{w: 1'b1, a: 17'h1_FFFF, d: 16'hFFFF, rd: 16'hBEEF, er: 1'b0};
    tbl[4] = '{w: 1'b0, a: 17'h0_0000, d: 16'h1111, rd: 16'h0000, er: 1'b0};
    tbl[5] = '{w: 1'b0, a: 17'h1_FFFF, d: 16'h2222, rd: 16'hFFFF, er: 1'b0};
    tbl[6] = '{w: 1'b1, a: 17'h0_0003, d: 16'h00A5, rd: 16'hFFFF, er: 1'b0};
    tbl[7] = '{w: 1'b0, a: 17'h0_0003, d: 16'h0000, rd: 16'h00A5, er: 1'b0};

    repeat (2) @(negedge clk);
    chk("rst.strobes", {ce_n, oe_n, we_n}, 3'b111);
    chk("rst.sram_addr", sram_addr, 0);
    chk("rst.sram_wdata", sram_wdata, 0);
    chk("rst.rsp_rdata", host.rsp_rdata, 0);
    chk("rst.rsp_valid", host.rsp_valid, 0);
    chk("rst.rsp_err", host.rsp_err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.req_ready", host.req_ready, 1);

    // Reset dropped in the middle of a read.
    host.req_valid = 1'b1;
    host.req_write = 1'b0;
    host.req_addr  = 17'h1_2345;
    @(posedge clk);
    #1 host.req_valid = 1'b0;
    @(posedge clk);
    #3;
    chk("t1.in_active", {ce_n, oe_n, we_n}, 3'b001);
    rst_n = 1'b0;
    #1;
    chk("t1.strobes_high", {ce_n, oe_n, we_n}, 3'b111);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("t1.req_ready", host.req_ready, 1);
    seen_v = 0;
    for (int i = 0; i < N + 8; i++) begin
      @(posedge clk);
      #1;
      if (host.rsp_valid) seen_v++;
    end
    chk("t1.no_rsp", seen_v, 0);
    chk("t1.rdata_kept", host.rsp_rdata, 0);

    for (int i = 0; i < 8; i++) begin
      run_vec($sformatf("vec%0d", i), tbl[i].w, tbl[i].a, tbl[i].d,
              tbl[i].rd, tbl[i].er);
      if (tbl[i].w) ref_mem[tbl[i].a] = tbl[i].d;
    end
    exp_last = 16'h00A5;

    // Read-back corruption only matters when the verify pass exists.
    flip = 1'b1;
    run_vec("t6.forced", 1'b1, 17'h0_0456, 16'h1234, exp_last, VER);
    flip = 1'b0;
    run_vec("t6.clean", 1'b1, 17'h0_0456, 16'h1234, exp_last, 1'b0);
    run_vec("t6.read", 1'b0, 17'h0_0456, 16'h0000, 16'h1234, 1'b0);
    ref_mem[17'h0_0456] = 16'h1234;
    exp_last = 16'h1234;

    t3_stream();

    begin
      logic [AB-1:0] pool [8];
      logic [AB-1:0] a;
      logic [W-1:0]  d, erd;
      logic          w;
      for (int i = 0; i < 8; i++) pool[i] = AB'($urandom);
      for (int k = 0; k < 40; k++) begin
        a = pool[$urandom_range(0, 7)];
        w = 1'($urandom_range(0, 1));
        if (!ref_mem.exists(a)) w = 1'b1;
        d = W'($urandom);
        erd = w ? exp_last : ref_mem[a];
        run_vec($sformatf("rnd%0d", k), w, a, d, erd, 1'b0);
        if (w) ref_mem[a] = d;
        else exp_last = erd;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
